ifu_fetch_resp: RTL and testbench
=================================

// Module: ifu_fetch_resp
// PURPOSE
// - Responder side of the PC fetch-address interface: accepts instruction addresses from the PC
//   block, fetches from an instruction-memory bus with variable grant/response latency, and returns
//   {addr, inst, err} to decode through a small response FIFO.
// - Sits between pc and the decoder; flush discards wrong-path fetches after any jump or branch redirect.
// PARAMETERS
// - ADDR_W     32  fetch address width
// - DATA_W     32  instruction width
// - FIFO_DEPTH 2   response FIFO entries (power of 2, >=2)
// PORTS
// - clk        in   1       system clock, all state on posedge
// - rst        in   1       asynchronous, active-high reset
// - req_valid  in   1       fetch request from PC
// - req_ready  out  1       request accepted when req_valid & req_ready at posedge
// - req_addr   in   ADDR_W  fetch address
// - flush      in   1       redirect: drop in-flight and buffered fetches
// - mem_req    out  1       memory request, held until mem_gnt
// - mem_addr   out  ADDR_W  memory address, stable while mem_req
// - mem_gnt    in   1       memory accepted request this cycle
// - mem_rvalid in   1       read data valid (>=1 cycle after gnt)
// - mem_rdata  in   DATA_W  read data
// - rsp_valid  out  1       FIFO head valid
// - rsp_ready  in   1       decoder consumes head
// - rsp_addr   out  ADDR_W  address of head entry
// - rsp_inst   out  DATA_W  instruction of head entry (0 when rsp_err)
// - rsp_err    out  1       head entry was misaligned (addr[1:0]!=0)
// BEHAVIOUR
// - Reset: state IDLE, FIFO empty; req_ready=0 during rst, mem_req=0, mem_addr=0, rsp_valid=0,
//   rsp_addr/inst/err=0. Reset mid-transaction drops everything; a late mem_rvalid after reset
//   is ignored (state IDLE).
// - req_ready = (state==IDLE) & (count + occupied-in-flight < FIFO_DEPTH) & ~flush; one outstanding access.
// - FSM: IDLE -accept aligned-> REQ; REQ -mem_gnt-> WAIT; WAIT -mem_rvalid-> IDLE (push entry);
//   WAIT -flush-> DROP; REQ -flush-> REQ with drop flag set (mem_req kept until gnt, then DROP);
//   DROP -mem_rvalid-> IDLE (data discarded).
// - mem_req/mem_addr registered: asserted the cycle after acceptance; never deasserted before mem_gnt.
// - Misaligned accept: no memory access; entry {addr, 0, err=1} pushed at the accept edge; stays IDLE.
// - Latency: accept T, mem_req at T+1, gnt at G>=T+1, rvalid at R>=G+1, rsp_valid at R+1.
// - FIFO: push at rvalid edge, pop when rsp_valid & rsp_ready; simultaneous push/pop when full is legal
//   (count unchanged); pointers wrap modulo FIFO_DEPTH; push into full FIFO cannot occur by construction.
// - flush: FIFO cleared at that edge (a same-cycle pop and a same-cycle rvalid are both discarded);
//   rsp_valid=0 next cycle; next request accepted only once state returns to IDLE.
// - flush in IDLE with empty FIFO: no effect besides blocking req_ready for that cycle.
// CONFIGURATION
// - IFU_PERF_CNT_EN defined: extra outputs perf_fetch_cnt[31:0] (responses pushed, incl. err)
//   and perf_stall_cnt[31:0] (cycles in REQ/WAIT/DROP); reset to 0, wrap at 2^32, not cleared by flush.
// - IFU_PERF_CNT_EN undefined: those ports and counters do not exist; all other behaviour identical.
// TESTING
// - Reset, req 0x80000000, gnt 1 cycle after mem_req, rvalid next cycle data 0x00000413
//   -> rsp_valid with addr 0x80000000, inst 0x00000413, err 0, 4 cycles after accept.
// - Back-to-back 0x80000000/0x80000004, rsp_ready=0 -> FIFO fills to 2, req_ready=0 until one pop.
// - mem_gnt delayed 5 cycles -> mem_req/mem_addr stable all 5 cycles, no second request issued.
// - flush while in WAIT, rvalid later with 0xDEADBEEF -> data dropped, rsp_valid stays 0, then IDLE.
// - req_addr 0x80000002 -> no mem_req; rsp_err=1, rsp_inst=0, rsp_addr=0x80000002.
// - rst asserted in WAIT -> all outputs 0 immediately; subsequent stray rvalid ignored.

Source files
------------

// File: rtl/ifu_fetch_resp.sv
// Instruction fetch responder: PC fetch requests -> instruction memory bus -> response FIFO to decode.
// Define IFU_PERF_CNT_EN to add the perf_fetch_cnt / perf_stall_cnt outputs.
module ifu_fetch_resp #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_inst,
    output logic              rsp_err
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DROP = 2'd3
    } state_e;

    state_e            state_r;
    state_e            state_next_s;
    logic              drop_r;
    logic              mem_req_r;
    logic [ADDR_W-1:0] mem_addr_r;

    logic [ADDR_W-1:0]     fifo_addr_r [FIFO_DEPTH];
    logic [DATA_W-1:0]     fifo_inst_r [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_err_r;
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      count_r;

    logic              req_ready_s;
    logic              accept_s;
    logic              misalign_s;
    logic              launch_s;
    logic              fetch_done_s;
    logic              push_s;
    logic              pop_s;
    logic              rsp_valid_s;
    logic [ADDR_W-1:0] push_addr_s;
    logic [DATA_W-1:0] push_inst_s;
    logic              push_err_s;

    // State register; drop_r remembers a flush seen while the request is still awaiting grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            drop_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            drop_r  <= (state_r == ST_REQ) & ~mem_gnt & (drop_r | flush);
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (launch_s) state_next_s = ST_REQ;
                else          state_next_s = ST_IDLE;
            end
            ST_REQ: begin
                if (mem_gnt) begin
                    if (drop_r | flush) state_next_s = ST_DROP;
                    else                state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) state_next_s = ST_IDLE;
                else if (flush) state_next_s = ST_DROP;
                else            state_next_s = ST_WAIT;
            end
            ST_DROP: begin
                if (mem_rvalid) state_next_s = ST_IDLE;
                else            state_next_s = ST_DROP;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Handshake decode; a response arriving together with flush is discarded
    always_comb begin
        rsp_valid_s  = (count_r != {CNT_W{1'b0}});
        req_ready_s  = ~rst & (state_r == ST_IDLE) & (count_r < DEPTH_C) & ~flush;
        accept_s     = req_valid & req_ready_s;
        misalign_s   = accept_s & (req_addr[1:0] != 2'b00);
        launch_s     = accept_s & (req_addr[1:0] == 2'b00);
        fetch_done_s = (state_r == ST_WAIT) & mem_rvalid & ~flush;
        push_s       = fetch_done_s | misalign_s;
        pop_s        = rsp_valid_s & rsp_ready & ~flush;
        if (misalign_s) begin
            push_addr_s = req_addr;
            push_inst_s = {DATA_W{1'b0}};
            push_err_s  = 1'b1;
        end else begin
            push_addr_s = mem_addr_r;
            push_inst_s = mem_rdata;
            push_err_s  = 1'b0;
        end
    end

    // Memory request port: raised on accept, held with a stable address until granted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req_r  <= 1'b0;
            mem_addr_r <= {ADDR_W{1'b0}};
        end else if (launch_s) begin
            mem_req_r  <= 1'b1;
            mem_addr_r <= req_addr;
        end else if (mem_req_r && mem_gnt) begin
            mem_req_r  <= 1'b0;
        end
    end

    // Response FIFO storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_addr_r[i] <= {ADDR_W{1'b0}};
                fifo_inst_r[i] <= {DATA_W{1'b0}};
            end
            fifo_err_r <= {FIFO_DEPTH{1'b0}};
        end else if (push_s) begin
            fifo_addr_r[wr_ptr_r] <= push_addr_s;
            fifo_inst_r[wr_ptr_r] <= push_inst_s;
            fifo_err_r[wr_ptr_r]  <= push_err_s;
        end
    end

    // Response FIFO pointers and occupancy; flush empties it outright
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt_r;
    logic [31:0] perf_stall_cnt_r;

    // Performance counters, free-running and unaffected by flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt_r <= 32'd0;
            perf_stall_cnt_r <= 32'd0;
        end else begin
            if (push_s)             perf_fetch_cnt_r <= perf_fetch_cnt_r + 32'd1;
            if (state_r != ST_IDLE) perf_stall_cnt_r <= perf_stall_cnt_r + 32'd1;
        end
    end

    assign perf_fetch_cnt = perf_fetch_cnt_r;
    assign perf_stall_cnt = perf_stall_cnt_r;
`endif

    assign req_ready = req_ready_s;
    assign mem_req   = mem_req_r;
    assign mem_addr  = mem_addr_r;
    assign rsp_valid = rsp_valid_s;
    assign rsp_addr  = fifo_addr_r[rd_ptr_r];
    assign rsp_inst  = fifo_inst_r[rd_ptr_r];
    assign rsp_err   = fifo_err_r[rd_ptr_r];

endmodule

// File: tb/tb_ifu_fetch_resp.sv
// Self-checking bench for ifu_fetch_resp: directed scenarios then randomized traffic against a
// transaction-level model (expected-response queue plus one outstanding-fetch record).
module tb_ifu_fetch_resp;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'h0;
    logic        flush = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_addr;
    logic [31:0] rsp_inst;
    logic        rsp_err;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    ifu_fetch_resp #(.ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .flush(flush),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_addr(rsp_addr), .rsp_inst(rsp_inst), .rsp_err(rsp_err)
`ifdef IFU_PERF_CNT_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] inst;
        logic        err;
    } rsp_t;

    rsp_t        exp_q[$];
    bit          busy, granted, dropped, last_acc, use_fixed, stray_rv;
    logic [31:0] fl_addr, fl_data, next_data;
    int          gnt_cnt, rv_cnt, next_gnt_dly, next_rv_dly;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        busy    = 1'b0;
        granted = 1'b0;
        dropped = 1'b0;
        exp_q.delete();
    endtask

    // One clock cycle, entered and left just after a negative edge.
    task automatic cyc(input logic rv, input logic [31:0] ra, input logic fl, input logic rr);
        logic gnt_v, rval_v, rdy_exp, pop;
        rsp_t e;
        chk("rsp_valid", rsp_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            chk("rsp_addr", rsp_addr, exp_q[0].addr);
            chk("rsp_inst", rsp_inst, exp_q[0].inst);
            chk("rsp_err", rsp_err, exp_q[0].err);
        end
        chk("mem_req", mem_req, busy && !granted);
        if (busy && !granted) chk("mem_addr", mem_addr, fl_addr);

        gnt_v  = 1'b0;
        rval_v = 1'b0;
        if (busy && !granted) begin
            if (gnt_cnt == 0) gnt_v = 1'b1;
            else gnt_cnt--;
        end else if (busy && granted) begin
            if (rv_cnt == 0) rval_v = 1'b1;
            else rv_cnt--;
        end
        req_valid  = rv;
        req_addr   = ra;
        flush      = fl;
        rsp_ready  = rr;
        mem_gnt    = gnt_v;
        mem_rvalid = rval_v | stray_rv;
        mem_rdata  = rval_v ? fl_data : $urandom();
        #1;
        rdy_exp = !busy && (exp_q.size() < DEPTH) && !fl;
        chk("req_ready", req_ready, rdy_exp);

        last_acc = rv && rdy_exp;
        pop = (exp_q.size() != 0) && rr && !fl;
        if (pop) void'(exp_q.pop_front());
        if (busy && granted && rval_v) begin
            busy = 1'b0;
            if (!dropped && !fl) begin
                e = '{fl_addr, fl_data, 1'b0};
                exp_q.push_back(e);
            end
        end
        if (busy && !granted && gnt_v) begin
            granted = 1'b1;
            rv_cnt  = use_fixed ? next_rv_dly : int'($urandom_range(0, 3));
        end
        if (fl) begin
            exp_q.delete();
            if (busy) dropped = 1'b1;
        end
        if (last_acc) begin
            if (ra[1:0] != 2'b00) begin
                e = '{ra, 32'h0, 1'b1};
                exp_q.push_back(e);
            end else begin
                busy    = 1'b1;
                granted = 1'b0;
                dropped = 1'b0;
                fl_addr = ra;
                fl_data = use_fixed ? next_data : $urandom();
                gnt_cnt = use_fixed ? next_gnt_dly : int'($urandom_range(0, 4));
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] a;
        reset_model();
        stray_rv  = 1'b0;
        use_fixed = 1'b1;

        // Reset values while rst is held
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_addr", rsp_addr, 32'h0);
        chk("rst_rsp_inst", rsp_inst, 32'h0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Basic fetch: gnt one cycle after mem_req, rvalid the cycle after gnt
        next_gnt_dly = 1; next_rv_dly = 0; next_data = 32'h0000_0413;
        cyc(1'b1, 32'h8000_0000, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        chk("basic_not_early", rsp_valid, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        chk("basic_valid", rsp_valid, 1'b1);
        chk("basic_addr", rsp_addr, 32'h8000_0000);
        chk("basic_inst", rsp_inst, 32'h0000_0413);
        chk("basic_err", rsp_err, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b1);

        // Back-to-back fetches with decode stalled fill the FIFO
        next_gnt_dly = 0; next_rv_dly = 0; next_data = 32'h1234_5678;
        a = 32'h8000_0000;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, a, 1'b0, 1'b0);
            if (last_acc) a = a + 32'd4;
        end
        chk("full_valid", rsp_valid, 1'b1);
        chk("full_ready", req_ready, 1'b0);
        chk("full_head", rsp_addr, 32'h8000_0000);
        cyc(1'b1, a, 1'b0, 1'b1);
        chk("after_pop_head", rsp_addr, 32'h8000_0004);
        chk("after_pop_ready", req_ready, 1'b1);
        cyc(1'b1, a, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) cyc(1'b0, 32'h0, 1'b0, 1'b1);

        // Grant held off: request and address must stay put
        next_gnt_dly = 5; next_rv_dly = 1; next_data = 32'hCAFE_0001;
        cyc(1'b1, 32'h8000_0100, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("slow_gnt_req", mem_req, 1'b1);
            chk("slow_gnt_addr", mem_addr, 32'h8000_0100);
            cyc(1'b1, 32'h8000_0200, 1'b0, 1'b1);
        end
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) cyc(1'b0, 32'h0, 1'b0, 1'b1);

        // Flush while waiting for data: the late response is dropped
        next_gnt_dly = 0; next_rv_dly = 4; next_data = 32'hDEAD_BEEF;
        cyc(1'b1, 32'h8000_0300, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h8000_0304, 1'b0, 1'b0);
        chk("flush_dropped", rsp_valid, 1'b0);
        next_rv_dly = 0; next_data = 32'h0000_0013;
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h8000_0304, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b0, 32'h0, 1'b0, 1'b1);

        // Misaligned address returns an error entry with no memory access
        cyc(1'b1, 32'h8000_0002, 1'b0, 1'b0);
        chk("mis_mem_req", mem_req, 1'b0);
        chk("mis_valid", rsp_valid, 1'b1);
        chk("mis_err", rsp_err, 1'b1);
        chk("mis_inst", rsp_inst, 32'h0);
        chk("mis_addr", rsp_addr, 32'h8000_0002);
        cyc(1'b0, 32'h0, 1'b0, 1'b1);

        // Reset in the middle of a fetch, then a stray rvalid
        next_gnt_dly = 0; next_rv_dly = 6; next_data = 32'h5555_AAAA;
        cyc(1'b1, 32'h8000_0400, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        rst = 1'b1; req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        #1;
        chk("midrst_mem_req", mem_req, 1'b0);
        chk("midrst_mem_addr", mem_addr, 32'h0);
        chk("midrst_rsp_valid", rsp_valid, 1'b0);
        chk("midrst_req_ready", req_ready, 1'b0);
        reset_model();
        @(negedge clk);
        rst = 1'b0;
        stray_rv = 1'b1;
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        stray_rv = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b0, 1'b1);
        chk("stray_ignored", rsp_valid, 1'b0);

        // Randomized traffic
        use_fixed = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            a = 32'h8000_0000 + ($urandom_range(0, 255) << 2);
            if ($urandom_range(0, 7) == 0) a = a + $urandom_range(1, 3);
            cyc($urandom_range(0, 2) != 0, a, $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1);
        end
        for (int i = 0; i < 12; i++) cyc(1'b0, 32'h0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
